// File: rtl/dac_mux_pkg.sv
// Shared types, default timing and width helpers for the DAC/mux serial driver.
// Defaults are sized for the ZCU102 system clock.
package dac_mux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_LOAD,
    ST_SETTLE,
    ST_STROBE,
    ST_CLEAR
  } dac_state_t;

  localparam int DEF_DATA_W     = 12;
  localparam int DEF_N_CH       = 8;
  localparam int DEF_HALF_CYC   = 2;
  localparam int DEF_LD_CYC     = 2;
  localparam int DEF_SETTLE_CYC = 128;
  localparam int DEF_MUX_CYC    = 2;
  localparam int DEF_CLR_CYC    = 2;

  // SCLK-high cycles after the last rising edge, giving LD setup time
  localparam int GAP_CYC = 2;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a down-counter that is loaded with max_val-1
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dac_serial_shifter.sv
// MSB-first serial shifter: SCLK low for HALF_CYC then high for HALF_CYC per bit,
// SDI changes on entry to the low phase. o_done flags the final cycle of the last bit.
module dac_serial_shifter
  import dac_mux_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int HALF_CYC = DEF_HALF_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_sdi_clr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_sclk,
  output logic              o_sdi,
  output logic              o_done
);

  localparam int HC_W  = cnt_width(HALF_CYC);
  localparam int BIT_W = cnt_width(DATA_W);
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HALF_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  logic              r_active;
  logic              r_high;
  logic              r_sclk;
  logic              r_sdi;
  logic [DATA_W-1:0] r_shreg;
  logic [HC_W-1:0]   r_half_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              w_half_tc;

  assign w_half_tc = (r_half_cnt == '0);
  assign o_done    = r_active && r_high && w_half_tc && (r_bit_cnt == '0);
  assign o_sclk    = r_sclk;
  assign o_sdi     = r_sdi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active   <= 1'b0;
      r_high     <= 1'b1;
      r_sclk     <= 1'b1;
      r_sdi      <= 1'b0;
      r_shreg    <= '0;
      r_half_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_start) begin
      r_active   <= 1'b1;
      r_high     <= 1'b0;
      r_sclk     <= 1'b0;
      r_sdi      <= i_data[DATA_W-1];
      r_shreg    <= {i_data[DATA_W-2:0], 1'b0};
      r_half_cnt <= HC_LAST;
      r_bit_cnt  <= BIT_LAST;
    end else if (r_active) begin
      if (!w_half_tc) begin
        r_half_cnt <= r_half_cnt - 1'b1;
      end else if (!r_high) begin
        r_high     <= 1'b1;
        r_sclk     <= 1'b1;
        r_half_cnt <= HC_LAST;
      end else if (r_bit_cnt == '0) begin
        // SCLK parks high and SDI keeps the LSB through the gap
        r_active <= 1'b0;
      end else begin
        r_high     <= 1'b0;
        r_sclk     <= 1'b0;
        r_sdi      <= r_shreg[DATA_W-1];
        r_shreg    <= r_shreg << 1;
        r_bit_cnt  <= r_bit_cnt - 1'b1;
        r_half_cnt <= HC_LAST;
      end
    end else if (i_sdi_clr) begin
      r_sdi <= 1'b0;
    end
  end

endmodule

// File: rtl/dac_mux_serial_driver.sv
// Serial driver for a DAC7611-class DAC feeding an analog mux: shift sample, pulse LD,
// settle, then strobe the one-hot mux select. Also issues requestable CLR pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | ready for a sample; pending clear takes priority
// ST_SHIFT  | shifter clocking out the sample MSB-first
// ST_GAP    | SCLK high, SDI holds LSB, LD setup
// ST_LOAD   | dac_ld_n low for LD_CYC
// ST_SETTLE | all pins idle for SETTLE_CYC
// ST_STROBE | mux_sel one-hot for MUX_CYC
// ST_CLEAR  | dac_clr_n low for CLR_CYC
module dac_mux_serial_driver
  import dac_mux_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int N_CH       = DEF_N_CH,
  parameter int HALF_CYC   = DEF_HALF_CYC,
  parameter int LD_CYC     = DEF_LD_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int MUX_CYC    = DEF_MUX_CYC,
  parameter int CLR_CYC    = DEF_CLR_CYC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [ch_width(N_CH)-1:0] in_ch,
  input  logic                      clr_req,
  output logic                      busy,
  output logic                      dac_sclk,
  output logic                      dac_sdi,
  output logic                      dac_ld_n,
  output logic                      dac_clr_n,
  output logic [N_CH-1:0]           mux_sel
);

  localparam int CH_W  = ch_width(N_CH);
  localparam int T_MAX = imax(imax(imax(GAP_CYC, LD_CYC), imax(SETTLE_CYC, MUX_CYC)), CLR_CYC);
  localparam int CNT_W = cnt_width(T_MAX);

  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LAST     = CNT_W'(LD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] MUX_LAST    = CNT_W'(MUX_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYC - 1);

  dac_state_t       r_state;
  dac_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_load;
  logic             w_cnt_tc;
  logic             r_pend;
  logic             w_pend_nxt;
  logic [CH_W-1:0]  r_ch;
  logic             w_start;
  logic             w_sdi_clr;
  logic             w_done;
  logic [N_CH-1:0]  w_onehot;

  logic             r_ready;
  logic             r_busy;
  logic             r_ld_n;
  logic             r_clr_n;
  logic [N_CH-1:0]  r_mux;
  logic             w_sclk;
  logic             w_sdi;

  dac_serial_shifter #(
    .DATA_W   (DATA_W),
    .HALF_CYC (HALF_CYC)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_sdi_clr (w_sdi_clr),
    .i_data    (in_data),
    .o_sclk    (w_sclk),
    .o_sdi     (w_sdi),
    .o_done    (w_done)
  );

  assign w_cnt_tc  = (r_cnt == '0);
  assign in_ready  = r_ready;
  assign busy      = r_busy;
  assign dac_sclk  = w_sclk;
  assign dac_sdi   = w_sdi;
  assign dac_ld_n  = r_ld_n;
  assign dac_clr_n = r_clr_n;
  assign mux_sel   = r_mux;

  // Out-of-range channel indices match no bit and leave the mux dark
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_ch == CH_W'(i)) w_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (w_cnt_load) r_cnt <= w_cnt_load_val;
      else if (!w_cnt_tc) r_cnt <= r_cnt - 1'b1;
      if (w_start) r_ch <= in_ch;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_start        = 1'b0;
    w_sdi_clr      = 1'b0;
    w_pend_nxt     = r_pend | (clr_req && (r_state != ST_IDLE));
    case (r_state)
      ST_IDLE: begin
        if (r_pend || clr_req) begin
          w_state_nxt    = ST_CLEAR;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = CLR_LAST;
          w_pend_nxt     = 1'b0;
        end else if (in_valid && r_ready) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_done) begin
          w_state_nxt    = ST_GAP;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = GAP_LAST;
        end
      end
      ST_GAP: begin
        if (w_cnt_tc) begin
          w_state_nxt    = ST_LOAD;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = LD_LAST;
        end
      end
      ST_LOAD: begin
        if (w_cnt_tc) begin
          w_state_nxt    = ST_SETTLE;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = SETTLE_LAST;
          w_sdi_clr      = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_cnt_tc) begin
          w_state_nxt    = ST_STROBE;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = MUX_LAST;
        end
      end
      ST_STROBE: begin
        if (w_cnt_tc) w_state_nxt = ST_IDLE;
      end
      ST_CLEAR: begin
        if (w_cnt_tc) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pins are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_ld_n  <= 1'b1;
      r_clr_n <= 1'b1;
      r_mux   <= '0;
    end else begin
      r_ready <= (w_state_nxt == ST_IDLE) && !w_pend_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_ld_n  <= (w_state_nxt != ST_LOAD);
      r_clr_n <= (w_state_nxt != ST_CLEAR);
      r_mux   <= (w_state_nxt == ST_STROBE) ? w_onehot : '0;
    end
  end

endmodule

// File: tb/tb_dac_mux_serial_driver.sv
// Directed bench for dac_mux_serial_driver: default 8-channel instance plus a 6-channel
// instance sharing the same stimulus for the out-of-range channel case.
module tb_dac_mux_serial_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        clr_req;
  logic [11:0] in_data;
  logic [2:0]  in_ch;

  logic       in_ready, busy, dac_sclk, dac_sdi, dac_ld_n, dac_clr_n;
  logic [7:0] mux_sel;
  logic       in_ready_6, busy_6, dac_sclk_6, dac_sdi_6, dac_ld_n_6, dac_clr_n_6;
  logic [5:0] mux_sel_6;

  int n_cmp = 0;
  int n_err = 0;

  int rises, first_rise, last_rise, bad_sp, ld_first, ld_cnt, clr_first, clr_cnt;
  int mux_first, mux_cnt, ready_first, busy_low_first, rises6, ld6_cnt, mux6_cnt;
  logic [11:0] bits, bits6;
  logic [7:0]  mux_val;

  dac_mux_serial_driver u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ch     (in_ch),
    .clr_req   (clr_req),
    .busy      (busy),
    .dac_sclk  (dac_sclk),
    .dac_sdi   (dac_sdi),
    .dac_ld_n  (dac_ld_n),
    .dac_clr_n (dac_clr_n),
    .mux_sel   (mux_sel)
  );

  dac_mux_serial_driver #(.N_CH(6)) u_dut6 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_6),
    .in_data   (in_data),
    .in_ch     (in_ch),
    .clr_req   (clr_req),
    .busy      (busy_6),
    .dac_sclk  (dac_sclk_6),
    .dac_sdi   (dac_sdi_6),
    .dac_ld_n  (dac_ld_n_6),
    .dac_clr_n (dac_clr_n_6),
    .mux_sel   (mux_sel_6)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps cycles k0..k1 relative to acceptance, logging pin events.
  // clr_req is raised at kc_on and dropped one cycle later; in_valid drops at kv_off.
  task automatic mon(input int k0, input int k1, input int kc_on, input int kv_off);
    logic prev, prev6;
    rises = 0; first_rise = -1; last_rise = -1; bad_sp = 0; bits = '0;
    ld_first = -1; ld_cnt = 0; clr_first = -1; clr_cnt = 0;
    mux_first = -1; mux_cnt = 0; mux_val = '0; ready_first = -1; busy_low_first = -1;
    rises6 = 0; bits6 = '0; ld6_cnt = 0; mux6_cnt = 0;
    prev = dac_sclk;
    prev6 = dac_sclk_6;
    for (int k = k0; k <= k1; k++) begin
      tick();
      if (!prev && dac_sclk) begin
        if (rises > 0 && (k - last_rise) != 4) bad_sp++;
        if (rises == 0) first_rise = k;
        last_rise = k;
        rises++;
        bits = {bits[10:0], dac_sdi};
      end
      prev = dac_sclk;
      if (!prev6 && dac_sclk_6) begin
        rises6++;
        bits6 = {bits6[10:0], dac_sdi_6};
      end
      prev6 = dac_sclk_6;
      if (!dac_ld_n) begin
        if (ld_first < 0) ld_first = k;
        ld_cnt++;
      end
      if (!dac_ld_n_6) ld6_cnt++;
      if (!dac_clr_n) begin
        if (clr_first < 0) clr_first = k;
        clr_cnt++;
      end
      if (mux_sel != 0) begin
        if (mux_first < 0) begin
          mux_first = k;
          mux_val = mux_sel;
        end
        mux_cnt++;
      end
      if (mux_sel_6 != 0) mux6_cnt++;
      if (in_ready && ready_first < 0) ready_first = k;
      if (!busy && busy_low_first < 0) busy_low_first = k;
      if (k == kc_on) clr_req = 1'b1;
      if (k == kc_on + 1) clr_req = 1'b0;
      if (k == kv_off) in_valid = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    clr_req = 1'b0;
    in_data = '0;
    in_ch = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_sclk", dac_sclk, 1);
    check("rst_sdi", dac_sdi, 0);
    check("rst_ld_n", dac_ld_n, 1);
    check("rst_clr_n", dac_clr_n, 1);
    check("rst_mux", mux_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);

    // Single frame 0x555 on ch 1
    in_valid = 1'b1; in_data = 12'h555; in_ch = 3'd1;
    tick();
    check("t1_ready_low", in_ready, 0);
    check("t1_busy", busy, 1);
    check("t1_sclk_first_low", dac_sclk, 0);
    in_valid = 1'b0;
    mon(2, 183, -1, -1);
    check("t1_rises", rises, 12);
    check("t1_bits", bits, 12'h555);
    check("t1_first_rise", first_rise, 3);
    check("t1_last_rise", last_rise, 47);
    check("t1_spacing", bad_sp, 0);
    check("t1_ld_first", ld_first, 51);
    check("t1_ld_cnt", ld_cnt, 2);
    check("t1_mux_first", mux_first, 181);
    check("t1_mux_val", mux_val, 8'b0000_0010);
    check("t1_mux_cnt", mux_cnt, 2);
    check("t1_busy_fall", busy_low_first, 183);
    check("t1_ready_back", ready_first, 183);
    check("t1_no_clr", clr_cnt, 0);

    // Back-to-back: 0xFFF ch 7 then 0x000 ch 0 with in_valid held
    in_valid = 1'b1; in_data = 12'hFFF; in_ch = 3'd7;
    tick();
    check("t2_ready_low", in_ready, 0);
    in_data = 12'h000; in_ch = 3'd0;
    mon(2, 183, -1, -1);
    check("t2a_bits", bits, 12'hFFF);
    check("t2a_mux_first", mux_first, 181);
    check("t2a_mux_val", mux_val, 8'h80);
    check("t2a_busy_fall", busy_low_first, 183);
    check("t2a_ready", in_ready, 1);
    tick();
    check("t2_second_accept", busy, 1);
    in_valid = 1'b0;
    mon(2, 183, -1, -1);
    check("t2b_rises", rises, 12);
    check("t2b_bits", bits, 12'h000);
    check("t2b_mux_first", mux_first, 181);
    check("t2b_mux_val", mux_val, 8'h01);

    // Clear requested mid-SHIFT
    in_valid = 1'b1; in_data = 12'hA5C; in_ch = 3'd3;
    tick();
    in_valid = 1'b0;
    mon(2, 190, 10, -1);
    check("t3_bits", bits, 12'hA5C);
    check("t3_ld_first", ld_first, 51);
    check("t3_mux_first", mux_first, 181);
    check("t3_mux_val", mux_val, 8'h08);
    check("t3_clr_first", clr_first, 184);
    check("t3_clr_cnt", clr_cnt, 2);
    check("t3_ready_first", ready_first, 186);

    // clr_req and in_valid together in IDLE
    clr_req = 1'b1; in_valid = 1'b1; in_data = 12'h3C3; in_ch = 3'd2;
    mon(1, 190, 0, 4);
    check("t4_clr_first", clr_first, 1);
    check("t4_clr_cnt", clr_cnt, 2);
    check("t4_ready_first", ready_first, 3);
    check("t4_first_rise", first_rise, 6);
    check("t4_bits", bits, 12'h3C3);
    check("t4_ld_first", ld_first, 54);
    check("t4_mux_first", mux_first, 184);
    check("t4_mux_val", mux_val, 8'h04);

    // Async reset during bit 5, with a clear pending
    in_valid = 1'b1; in_data = 12'h1E7; in_ch = 3'd5;
    tick();
    in_valid = 1'b0;
    mon(2, 22, 5, -1);
    check("t5_sclk_pre", dac_sclk, 0);
    check("t5_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("t5_sclk", dac_sclk, 1);
    check("t5_sdi", dac_sdi, 0);
    check("t5_ld_n", dac_ld_n, 1);
    check("t5_clr_n", dac_clr_n, 1);
    check("t5_mux", mux_sel, 0);
    check("t5_busy", busy, 0);
    check("t5_sclk6", dac_sclk_6, 1);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("t5_ready_after", in_ready, 1);
    check("t5_busy_after", busy, 0);
    in_valid = 1'b1; in_data = 12'h9A6; in_ch = 3'd6;
    tick();
    in_valid = 1'b0;
    mon(2, 190, -1, -1);
    check("t5_rises", rises, 12);
    check("t5_bits", bits, 12'h9A6);
    check("t5_ld_first", ld_first, 51);
    check("t5_mux_first", mux_first, 181);
    check("t5_mux_val", mux_val, 8'h40);
    check("t5_clr_dropped", clr_cnt, 0);

    // Channel 7 on the 6-channel instance
    in_valid = 1'b1; in_data = 12'h6B1; in_ch = 3'd7;
    tick();
    in_valid = 1'b0;
    mon(2, 183, -1, -1);
    check("t6_rises6", rises6, 12);
    check("t6_bits6", bits6, 12'h6B1);
    check("t6_ld6_cnt", ld6_cnt, 2);
    check("t6_mux6_dark", mux6_cnt, 0);
    check("t6_mux8_val", mux_val, 8'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
